// File: rtl/checkbits_mon_pkg.sv
// checkbits_mon_pkg: shared state type, default markers and index width for the progress monitor
package checkbits_mon_pkg;
  localparam int IDX_W = 8;
  localparam logic [15:0] START_MARK_DEF = 16'hAB40;
  localparam logic [15:0] END_MARK_DEF = 16'hAB51;
  typedef enum logic [1:0] {IDLE, ARMED, DONE_OK, DONE_TO} state_t;
endpackage

// File: rtl/checkbits_fifo.sv
// checkbits_fifo: sync FIFO with push-on-full accepted only alongside a pop, pop-on-empty ignored
module checkbits_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (rd) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clock)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/checkbits_monitor.sv
// checkbits_monitor: synchronises and debounces a progress field, captures samples between markers, flags pass/fail
module checkbits_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] START_MARK     = WIDTH'(START_MARK_DEF),
  parameter logic [WIDTH-1:0] END_MARK       = WIDTH'(END_MARK_DEF),
  parameter int               EXP_SAMPLES    = 11,
  parameter int               DEPTH          = 16,
  parameter int               SYNC_STAGES    = 2,
  parameter int               STABLE_CYCLES  = 4,
  parameter int               TIMEOUT_CYCLES = 250000
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits_i,
  output logic [WIDTH-1:0] samp_data_o,
  output logic [IDX_W-1:0] samp_idx_o,
  output logic             samp_valid_o,
  input  logic             samp_ready_i,
  output logic             armed_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             overflow_o,
  output logic [IDX_W-1:0] samp_count_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] cand, hold, settled;
  logic [CW-1:0] run_q, run;
  logic [31:0] tcnt;
  logic [IDX_W-1:0] cnt_inc;
  logic [WIDTH+IDX_W-1:0] head;
  logic settle, timeout, push, pop, drop, full, empty, count_ok;
  state_t state, state_nx;
  assign cand = sync_q[SYNC_STAGES-1];
  // run = consecutive cycles the synchronised value has held, saturating at STABLE_CYCLES
  assign run = cand != hold ? CW'(1) : run_q == CW'(STABLE_CYCLES) ? run_q : run_q + CW'(1);
  assign settle = cand != settled && run >= CW'(STABLE_CYCLES);
  assign timeout = TIMEOUT_CYCLES != 0 && tcnt == 32'(TIMEOUT_CYCLES - 1);
  assign cnt_inc = &samp_count_o ? samp_count_o : samp_count_o + IDX_W'(1);
  assign count_ok = EXP_SAMPLES == 0 || samp_count_o == IDX_W'(EXP_SAMPLES);
  assign pop = samp_ready_i && !empty;
  assign drop = push && full && !pop;
  assign armed_o = state == ARMED;
  assign samp_valid_o = !empty;
  assign samp_data_o = empty ? '0 : head[WIDTH+IDX_W-1:IDX_W];
  assign samp_idx_o = empty ? '0 : head[IDX_W-1:0];
  // END_MARK settling beats a coincident timeout
  always_comb begin
    state_nx = state == IDLE && settle && cand == START_MARK ? ARMED :
               state == ARMED && settle && cand == END_MARK ? DONE_OK :
               (state == IDLE || state == ARMED) && timeout ? DONE_TO : state;
    push = state == ARMED && settle && cand != END_MARK;
  end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hold <= '0;
      run_q <= '0;
      settled <= '0;
    end else begin
      sync_q[0] <= checkbits_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hold <= cand;
      run_q <= run;
      if (settle) settled <= cand;
    end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      tcnt <= '0;
      samp_count_o <= '0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      fail_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE || state == ARMED) tcnt <= tcnt + 32'd1;
      if (push) samp_count_o <= cnt_inc;
      if (drop) overflow_o <= 1'b1;
      if (state_nx == DONE_OK && state != DONE_OK) begin
        done_o <= 1'b1;
        pass_o <= !overflow_o && count_ok;
        fail_o <= overflow_o || !count_ok;
      end
      if (state_nx == DONE_TO && state != DONE_TO) begin
        done_o <= 1'b1;
        fail_o <= 1'b1;
      end
    end
  checkbits_fifo #(.WIDTH(WIDTH + IDX_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .resetb(resetb),
    .push  (push),
    .pop   (pop),
    .din   ({cand, cnt_inc}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_checkbits_monitor.sv
// tb_checkbits_monitor: randomized self-checking bench with a sample-level reference model
module tb_checkbits_monitor;
  localparam int STABLE = 4, DEPTH = 4, EXP = 11, TO = 1000;
  localparam logic [15:0] SM = 16'hAB40, EM = 16'hAB51;
  logic clock = 1'b0, resetb = 1'b0, samp_ready = 1'b0, ready2 = 1'b1;
  logic [15:0] checkbits = '0;
  logic [15:0] samp_data, samp_data2;
  logic [7:0] samp_idx, samp_idx2, samp_count, samp_count2;
  logic samp_valid, armed, done, pass, fail, overflow;
  logic samp_valid2, armed2, done2, pass2, fail2, overflow2;
  int checks = 0, failures = 0;
  int m_state, m_count;
  bit m_done, m_pass, m_fail, m_over;
  logic [15:0] m_settled;
  logic [23:0] m_q[$];
  always #5 clock = ~clock;
  checkbits_monitor #(.EXP_SAMPLES(EXP), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetb(resetb), .checkbits_i(checkbits),
    .samp_data_o(samp_data), .samp_idx_o(samp_idx), .samp_valid_o(samp_valid),
    .samp_ready_i(samp_ready), .armed_o(armed), .done_o(done), .pass_o(pass),
    .fail_o(fail), .overflow_o(overflow), .samp_count_o(samp_count));
  checkbits_monitor #(.EXP_SAMPLES(0), .DEPTH(16), .TIMEOUT_CYCLES(TO)) dut_any (
    .clock(clock), .resetb(resetb), .checkbits_i(checkbits),
    .samp_data_o(samp_data2), .samp_idx_o(samp_idx2), .samp_valid_o(samp_valid2),
    .samp_ready_i(ready2), .armed_o(armed2), .done_o(done2), .pass_o(pass2),
    .fail_o(fail2), .overflow_o(overflow2), .samp_count_o(samp_count2));
  function automatic void m_apply(logic [15:0] v, int h);
    if (h < STABLE || v == m_settled) return;
    m_settled = v;
    if (m_state == 0 && v == SM) m_state = 1;
    else if (m_state == 1 && v == EM) begin
      m_state = 2;
      m_done = 1;
      if (!m_over && m_count == EXP) m_pass = 1; else m_fail = 1;
    end else if (m_state == 1) begin
      if (m_count < 255) m_count++;
      if (m_q.size() < DEPTH) m_q.push_back({v, 8'(m_count)}); else m_over = 1;
    end
  endfunction
  task automatic step();
    logic [23:0] e;
    if (samp_valid && samp_ready) begin
      checks++;
      if (m_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got data=%h idx=%0d required no entry", samp_data, samp_idx);
      end else begin
        e = m_q.pop_front();
        if ({samp_data, samp_idx} !== e) begin
          failures++;
          $display("FAIL pop_entry got data=%h idx=%0d required data=%h idx=%0d", samp_data, samp_idx, e[23:8], e[7:0]);
        end
      end
    end
    @(negedge clock);
  endtask
  task automatic send(logic [15:0] v, int h);
    checkbits = v;
    m_apply(v, h);
    repeat (h) step();
  endtask
  task automatic do_reset();
    resetb = 1'b0;
    checkbits = '0;
    samp_ready = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    m_state = 0; m_count = 0; m_done = 0; m_pass = 0; m_fail = 0; m_over = 0;
    m_settled = '0;
    m_q.delete();
  endtask
  task automatic drain();
    samp_ready = 1'b1;
    for (int i = 0; i < 40 && (samp_valid || m_q.size() != 0); i++) step();
    checks++;
    if (samp_valid !== 1'b0 || m_q.size() != 0) begin
      failures++;
      $display("FAIL drain valid=%b left=%0d required valid=0 left=0", samp_valid, m_q.size());
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({samp_valid, armed, done, pass, fail, overflow, samp_count, samp_data, samp_idx} !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b a=%b d=%b p=%b f=%b o=%b c=%0d required all 0", samp_valid, armed, done, pass, fail, overflow, samp_count);
    end
  endtask
  task automatic test_nominal();
    do_reset();
    samp_ready = 1'b1;
    send(SM, 10);
    for (int i = 1; i <= 11; i++) send(16'(i), 10);
    checks++;
    if ({armed, samp_count} !== {1'b1, 8'd11}) begin
      failures++;
      $display("FAIL nominal_armed got armed=%b count=%0d required armed=1 count=11", armed, samp_count);
    end
    send(EM, 10);
    drain();
    checks++;
    if ({done, pass, fail, overflow, armed, pass2} !== {m_done, m_pass, m_fail, m_over, m_state == 1, 1'b1} || m_pass != 1) begin
      failures++;
      $display("FAIL nominal_verdict got d=%b p=%b f=%b o=%b a=%b p2=%b required d=1 p=1 f=0 o=0 a=0 p2=1", done, pass, fail, overflow, armed, pass2);
    end
  endtask
  task automatic test_glitch();
    do_reset();
    samp_ready = 1'b1;
    send(SM, 10);
    send(16'd3, 10);
    send(16'd5, 2);
    send(16'd3, 10);
    checks++;
    if (samp_count !== 8'd1 || m_count != 1) begin
      failures++;
      $display("FAIL glitch_count got %0d required 1", samp_count);
    end
    send(16'd5, 10);
    checks++;
    if (samp_count !== 8'(m_count)) begin
      failures++;
      $display("FAIL glitch_after got %0d required %0d", samp_count, m_count);
    end
    drain();
  endtask
  task automatic test_count_mismatch();
    do_reset();
    samp_ready = 1'b1;
    send(SM, 10);
    for (int i = 1; i <= 10; i++) send(16'(i + 100), 8);
    send(EM, 10);
    drain();
    checks++;
    if ({done, pass, fail, samp_count} !== {3'b101, 8'd10}) begin
      failures++;
      $display("FAIL mismatch_verdict got d=%b p=%b f=%b c=%0d required d=1 p=0 f=1 c=10", done, pass, fail, samp_count);
    end
    checks++;
    if ({done2, pass2, fail2} !== 3'b110) begin
      failures++;
      $display("FAIL anycount_verdict got d=%b p=%b f=%b required d=1 p=1 f=0", done2, pass2, fail2);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    send(SM, 10);
    for (int i = 1; i <= 5; i++) send(16'(i * 7), 10);
    checks++;
    if ({overflow, samp_count, samp_valid, samp_idx} !== {m_over, 8'(m_count), 1'b1, 8'd1} || !m_over) begin
      failures++;
      $display("FAIL overflow_flag got o=%b c=%0d v=%b idx=%0d required o=1 c=5 v=1 idx=1", overflow, samp_count, samp_valid, samp_idx);
    end
    send(EM, 10);
    checks++;
    if ({done, pass, fail} !== {m_done, m_pass, m_fail}) begin
      failures++;
      $display("FAIL overflow_verdict got d=%b p=%b f=%b required %b%b%b", done, pass, fail, m_done, m_pass, m_fail);
    end
    drain();
  endtask
  task automatic test_timeout();
    do_reset();
    repeat (TO - 1) step();
    checks++;
    if ({done, fail, done2} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_early got d=%b f=%b d2=%b required 000", done, fail, done2);
    end
    step();
    m_state = 2; m_done = 1; m_fail = 1;
    checks++;
    if ({done, pass, fail, done2, fail2} !== 5'b10111) begin
      failures++;
      $display("FAIL timeout_fire got d=%b p=%b f=%b d2=%b f2=%b required 10111", done, pass, fail, done2, fail2);
    end
    send(SM, 10);
    checks++;
    if ({armed, done, pass, fail, samp_valid} !== 5'b01010) begin
      failures++;
      $display("FAIL timeout_absorb got a=%b d=%b p=%b f=%b v=%b required 01010", armed, done, pass, fail, samp_valid);
    end
  endtask
  task automatic test_reset_midrun();
    do_reset();
    send(SM, 10);
    for (int i = 1; i <= 3; i++) send(16'(i + 40), 10);
    checks++;
    if ({armed, samp_count, samp_valid} !== {1'b1, 8'd3, 1'b1}) begin
      failures++;
      $display("FAIL midrun_pre got a=%b c=%0d v=%b required a=1 c=3 v=1", armed, samp_count, samp_valid);
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({samp_valid, armed, done, pass, fail, overflow, samp_count, samp_data, samp_idx} !== '0) begin
      failures++;
      $display("FAIL midrun_clear got v=%b a=%b c=%0d required all 0", samp_valid, armed, samp_count);
    end
    @(negedge clock);
    do_reset();
    samp_ready = 1'b1;
    send(SM, 10);
    send(16'h0077, 10);
    send(16'h0078, 10);
    checks++;
    if ({armed, samp_count} !== {1'b1, 8'd2}) begin
      failures++;
      $display("FAIL midrun_rearm got a=%b c=%0d required a=1 c=2", armed, samp_count);
    end
    drain();
  endtask
  task automatic test_random();
    int n;
    logic [15:0] v;
    do_reset();
    samp_ready = 1'b1;
    send(SM, 10);
    n = $urandom_range(12, 9);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(2, 0) == 0) send(16'($urandom), 2);
      v = 16'($urandom);
      if (v == EM) v = 16'h0001;
      send(v, $urandom_range(12, 6));
    end
    send(EM, 10);
    drain();
    checks++;
    if ({done, pass, fail, overflow, armed, samp_count} !== {m_done, m_pass, m_fail, m_over, m_state == 1, 8'(m_count)}) begin
      failures++;
      $display("FAIL random_verdict got d=%b p=%b f=%b o=%b a=%b c=%0d required d=%b p=%b f=%b o=%b c=%0d", done, pass, fail, overflow, armed, samp_count, m_done, m_pass, m_fail, m_over, m_count);
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_count_mismatch();
    test_overflow();
    test_timeout();
    test_reset_midrun();
    for (int r = 0; r < 3; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
